// File: rtl/prog_seq_ctrl.sv
// rtl/prog_seq_ctrl.sv - program sequencer control FSM (run/wait/halt/abort, retired-instruction count)
module prog_seq_ctrl #(
    parameter int WAIT_W = 16,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_host_start,
    input  logic              i_host_abort,
    input  logic [63:0]       i_pc,
    input  logic [63:0]       i_end_addr,
    input  logic              i_dec_valid,
    input  logic              i_dec_branch,
    input  logic              i_dec_taken,
    input  logic              i_dec_wait,
    input  logic [WAIT_W-1:0] i_dec_wait_cnt,
    input  logic              i_dec_halt,
    output logic              o_start_sig,
    output logic              o_sel_pc,
    output logic              o_end_sig,
    output logic              o_busy,
    output logic              o_done,
    output logic [CNT_W-1:0]  o_instr_cnt,
    output logic [1:0]        o_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WAIT_W-1:0] r_stall_cnt;
    logic [WAIT_W-1:0] w_stall_nxt;
    logic [CNT_W-1:0]  r_instr_cnt;
    logic              r_done;
    logic              w_retire;
    logic              w_clr_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_stall_cnt <= '0;
            r_instr_cnt <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_stall_cnt <= w_stall_nxt;
            r_done      <= (w_state_nxt == S_DONE);
            if (w_clr_cnt)
                r_instr_cnt <= '0;
            else if (w_retire && (r_instr_cnt != {CNT_W{1'b1}}))
                r_instr_cnt <= r_instr_cnt + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_stall_nxt = r_stall_cnt;
        w_retire    = 1'b0;
        w_clr_cnt   = 1'b0;
        o_start_sig = 1'b0;
        o_sel_pc    = 1'b0;
        o_end_sig   = 1'b1;
        o_busy      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_host_start && !i_host_abort) begin
                    w_state_nxt = S_RUN;
                    w_clr_cnt   = 1'b1;
                end
            end
            S_RUN: begin
                o_busy = 1'b1;
                if (i_host_abort) begin
                    w_state_nxt = S_IDLE;
                end else if ((i_dec_valid && i_dec_halt) || (i_pc == i_end_addr)) begin
                    w_state_nxt = S_DONE;
                end else if (i_dec_valid) begin
                    w_retire    = 1'b1;
                    o_start_sig = 1'b1;
                    o_end_sig   = 1'b0;
                    o_sel_pc    = i_dec_branch & i_dec_taken;
                    if (i_dec_wait && (i_dec_wait_cnt != '0)) begin
                        w_stall_nxt = i_dec_wait_cnt;
                        w_state_nxt = S_WAIT;
                    end
                end else begin
                    // Decoder bubble: neither advance nor hold-request.
                    o_end_sig = 1'b0;
                end
            end
            S_WAIT: begin
                o_busy = 1'b1;
                if (i_host_abort) begin
                    w_state_nxt = S_IDLE;
                    w_stall_nxt = '0;
                end else begin
                    w_stall_nxt = r_stall_cnt - 1'b1;
                    if (r_stall_cnt <= 1)
                        w_state_nxt = S_RUN;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign o_done      = r_done;
    assign o_instr_cnt = r_instr_cnt;
    assign o_state     = r_state;

endmodule

// File: doc/prog_seq_ctrl.md
PROG_SEQ_CTRL -- requirements
Module: prog_seq_ctrl

Interface
REQ-001 Parameter WAIT_W, default 16, width of the wait-count field and of the stall counter.
REQ-002 Parameter CNT_W, default 32, width of the retired-instruction counter.
REQ-003 clk  in  1  clock; state updates on the rising edge (PC register downstream samples on the falling edge).
REQ-004 reset  in  1  reset, synchronous, active-high.
REQ-005 i_host_start  in  1  one-cycle pulse that launches program execution.
REQ-006 i_host_abort  in  1  level abort request from the host.
REQ-007 i_pc  in  64  current PC, fed back from the PC register.
REQ-008 i_end_addr  in  64  last program address; execution ends when the PC reaches it.
REQ-009 i_dec_valid  in  1  decoded instruction at i_pc is valid this cycle.
REQ-010 i_dec_branch, i_dec_taken  in  1 each  branch instruction, and branch condition true.
REQ-011 i_dec_wait  in  1  timing-wait instruction.
REQ-012 i_dec_wait_cnt  in  WAIT_W  number of stall cycles requested by the wait instruction.
REQ-013 i_dec_halt  in  1  halt instruction.
REQ-014 o_start_sig  out  1  PC advance enable.
REQ-015 o_sel_pc  out  1  1 selects the ALU branch target; 0 selects PC+1.
REQ-016 o_end_sig  out  1  PC hold request.
REQ-017 o_busy  out  1  high in RUN and WAIT.
REQ-018 o_done  out  1  one-cycle completion pulse.
REQ-019 o_instr_cnt  out  CNT_W  count of retired instructions in the current run.
REQ-020 o_state  out  2  encoding: IDLE=0, RUN=1, WAIT=2, DONE=3.

Function
REQ-021 o_start_sig, o_sel_pc, o_end_sig and o_busy are combinational functions of the state and the decode inputs; all other outputs are registered.
REQ-022 IDLE: o_start_sig=0, o_end_sig=1. An i_host_start pulse moves the block to RUN and clears o_instr_cnt.
REQ-023 RUN: an instruction retires when i_dec_valid=1, i_host_abort=0, i_dec_halt=0 and i_pc!=i_end_addr. On retire, o_start_sig=1, o_end_sig=0, o_sel_pc=i_dec_branch&i_dec_taken, and o_instr_cnt increments.
REQ-024 RUN with i_dec_valid=0: o_start_sig=0, o_end_sig=0, and the block stays in RUN.
REQ-025 RUN priority, highest first: abort, halt, end address, wait, branch/sequential.
REQ-026 RUN with i_host_abort=1: o_start_sig=0, o_end_sig=1, next state IDLE, no o_done pulse.
REQ-027 RUN with (i_dec_valid & i_dec_halt) or i_pc==i_end_addr: o_start_sig=0, o_end_sig=1, next state DONE, no retire.
REQ-028 Wait instruction with i_dec_wait_cnt=N>0 retires (PC advances by 1), loads the stall counter with N, and moves to WAIT; N=0 behaves as a plain sequential instruction.
REQ-029 WAIT: o_start_sig=0, o_end_sig=1; the stall counter decrements every cycle and the block returns to RUN on the cycle it reads 1, giving exactly N stall cycles.
REQ-030 WAIT with i_host_abort=1 goes to IDLE next cycle and clears the stall counter.
REQ-031 DONE lasts exactly one cycle with o_done=1 and o_end_sig=1, then returns to IDLE.
REQ-032 i_host_start is ignored outside IDLE; i_host_start and i_host_abort together in IDLE leave the block in IDLE.
REQ-033 o_instr_cnt saturates at all-ones; it holds its value after DONE or abort until the next start.
REQ-034 o_sel_pc is 0 whenever o_start_sig=0.

Reset
REQ-035 While reset=1 at a rising edge: state=IDLE, stall counter=0, o_instr_cnt=0, o_done=0, giving o_start_sig=0, o_sel_pc=0, o_end_sig=1, o_busy=0.
REQ-036 Reset asserted in RUN or WAIT overrides all other inputs and gives IDLE on the next cycle.

Verification
REQ-037 Start pulse, i_end_addr=5, i_dec_valid=1, no branch -> 5 retire cycles (o_start_sig=1, o_sel_pc=0), then one DONE cycle with o_done=1 and o_instr_cnt=5, then IDLE.
REQ-038 Wait with N=3 at PC=2 -> o_start_sig=1 for the wait cycle, then exactly 3 cycles in WAIT with o_start_sig=0 and o_end_sig=1, then RUN resumes; N=0 -> no WAIT cycle.
REQ-039 Branch with taken=1 -> o_sel_pc=1 in that cycle; branch with taken=0 -> o_sel_pc=0; both increment o_instr_cnt.
REQ-040 Halt at PC=1 with i_end_addr=10 -> DONE next cycle, o_instr_cnt=1; halt together with wait -> halt wins.
REQ-041 Abort during WAIT with 2 stall cycles remaining -> IDLE next cycle, o_done stays 0, stall counter=0, o_busy=0.
REQ-042 Reset mid-RUN with o_instr_cnt=7 -> IDLE and o_instr_cnt=0 next cycle; a start pulse while in RUN causes no change.
